// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared defaults, status bundle and pointer wrap helper for the UART FIFO
package uart_fifo_pkg;
  localparam int DEF_WIDTH        = 8;
  localparam int DEF_DEPTH        = 128;
  localparam int DEF_AFULL_MARGIN = 4;
  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic geq_level;
  } fifo_status_t;
  function automatic int unsigned ptr_next(int unsigned ptr, int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/uart_fifo_if.sv
// uart_fifo_if: register-side handshake and status bundle of the UART FIFO
interface uart_fifo_if import uart_fifo_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CNT_BITS = $clog2(DEF_DEPTH + 1)
);
  logic                flush;
  logic [WIDTH-1:0]    data_in;
  logic                write_n;
  logic                read_n;
  logic [CNT_BITS-1:0] level;
  logic [WIDTH-1:0]    data_out;
  logic                data_valid;
  logic [CNT_BITS-1:0] count;
  logic                full;
  logic                empty;
  logic                afull;
  logic                geq_level;
  logic                overflow;
  logic                underflow;
  modport master (
    output flush, data_in, write_n, read_n, level,
    input  data_out, data_valid, count, full, empty, afull, geq_level, overflow, underflow
  );
  modport slave (
    input  flush, data_in, write_n, read_n, level,
    output data_out, data_valid, count, full, empty, afull, geq_level, overflow, underflow
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: dual-port storage, sync write, registered read with enable, no reset
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/uart_fifo_param.sv
// uart_fifo_param: parametrised UART FIFO with count, threshold and almost-full flags.
// Define UART_FIFO_ERR_EN to build the sticky overflow/underflow error flags.
module uart_fifo_param import uart_fifo_pkg::*; #(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AFULL_MARGIN = DEF_AFULL_MARGIN
) (
  input logic       clock,
  input logic       reset,
  uart_fifo_if.slave bus
);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int PTR_W    = $clog2(DEPTH);
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic [WIDTH-1:0]    rdata;
  logic                rd_acc, wr_acc, rd_go, wr_go, loaded, dv;
  fifo_status_t        st;
  assign st = '{
    full:      count == CNT_BITS'(DEPTH),
    empty:     count == '0,
    afull:     count >= CNT_BITS'(DEPTH - AFULL_MARGIN),
    geq_level: count >= bus.level
  };
  assign rd_acc = ~bus.read_n & ~st.empty;
  assign wr_acc = ~bus.write_n & (~st.full | rd_acc);
  assign rd_go  = rd_acc & ~bus.flush & ~reset;
  assign wr_go  = wr_acc & ~bus.flush & ~reset;
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dv     <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= PTR_W'(ptr_next(32'(wr_ptr), DEPTH));
      if (rd_acc) rd_ptr <= PTR_W'(ptr_next(32'(rd_ptr), DEPTH));
      if (wr_acc != rd_acc) count <= wr_acc ? count + 1'b1 : count - 1'b1;
      dv <= rd_acc;
    end
    if (reset) loaded <= 1'b0;
    else if (rd_go) loaded <= 1'b1;
  end
  // RAM output has no reset, so mask it until the first read after reset
  assign bus.data_out   = loaded ? rdata : '0;
  assign bus.data_valid = dv;
  assign bus.count      = count;
  assign bus.full       = st.full;
  assign bus.empty      = st.empty;
  assign bus.afull      = st.afull;
  assign bus.geq_level  = st.geq_level;
`ifdef UART_FIFO_ERR_EN
  logic ovf, unf;
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (~bus.write_n & st.full & ~rd_acc) ovf <= 1'b1;
      if (~bus.read_n & st.empty) unf <= 1'b1;
    end
  end
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
  uart_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
    .clock(clock),
    .we(wr_go),
    .waddr(wr_ptr),
    .wdata(bus.data_in),
    .re(rd_go),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_uart_fifo_param.sv
// tb_uart_fifo_param: directed bench for a 16-deep and a 5-deep FIFO instance
module tb_uart_fifo_param;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic done = 1'b0;
`ifdef UART_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  always #5 clock = ~clock;
  uart_fifo_if #(.WIDTH(8), .CNT_BITS(5)) a();
  uart_fifo_if #(.WIDTH(8), .CNT_BITS(3)) b();
  uart_fifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_MARGIN(4)) dut_a (.clock(clock), .reset(reset), .bus(a));
  uart_fifo_param #(.WIDTH(8), .DEPTH(5), .AFULL_MARGIN(1)) dut_b (.clock(clock), .reset(reset), .bus(b));
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: stimulus did not complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end
  initial begin
    a.flush = 0; a.write_n = 1; a.read_n = 1; a.data_in = 0; a.level = 0;
    b.flush = 0; b.write_n = 1; b.read_n = 1; b.data_in = 0; b.level = 0;
    repeat (2) cyc();
    reset = 0;
    checks++;
    if (a.count !== 0 || a.empty !== 1'b1 || a.full !== 1'b0 || a.afull !== 1'b0) begin
      errors++;
      $error("FAIL rst_state count=%0h empty=%0b full=%0b afull=%0b", a.count, a.empty, a.full, a.afull);
    end
    chk("rst_count", a.count, 0);
    chk("rst_empty", a.empty, 1);
    chk("rst_full", a.full, 0);
    chk("rst_afull", a.afull, 0);
    chk("rst_dout", a.data_out, 0);
    chk("rst_dv", a.data_valid, 0);
    chk("rst_ovf", a.overflow, 0);
    chk("rst_geq0", a.geq_level, 1);
    for (int i = 0; i < 16; i++) begin
      a.data_in = 8'(i); a.write_n = 0;
      cyc();
      chk("fill_count", a.count, i + 1);
      chk("fill_afull", a.afull, (i + 1 >= 12));
      chk("fill_full", a.full, (i == 15));
    end
    a.data_in = 8'hFF;
    cyc();
    chk("ovf_count", a.count, 16);
    chk("ovf_full", a.full, 1);
    chk("ovf_flag", a.overflow, ERR);
    chk("ovf_dv", a.data_valid, 0);
    a.read_n = 0; a.data_in = 8'h55;
    cyc();
    chk("fullrw_count", a.count, 16);
    chk("fullrw_dv", a.data_valid, 1);
    chk("fullrw_dout", a.data_out, 8'h00);
    a.write_n = 1;
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("drain_dout", a.data_out, (k < 15) ? 8'(k + 1) : 8'h55);
      chk("drain_dv", a.data_valid, 1);
      chk("drain_count", a.count, 15 - k);
    end
    chk("drain_empty", a.empty, 1);
    cyc();
    chk("unf_dv", a.data_valid, 0);
    chk("unf_dout", a.data_out, 8'h55);
    chk("unf_flag", a.underflow, ERR);
    chk("unf_count", a.count, 0);
    a.write_n = 0; a.data_in = 8'h77;
    cyc();
    chk("emptyrw_count", a.count, 1);
    chk("emptyrw_dv", a.data_valid, 0);
    chk("emptyrw_dout", a.data_out, 8'h55);
    chk("emptyrw_empty", a.empty, 0);
    a.write_n = 1;
    cyc();
    chk("rd77_dout", a.data_out, 8'h77);
    chk("rd77_dv", a.data_valid, 1);
    a.read_n = 1;
    a.level = 3;
    for (int i = 0; i < 3; i++) begin
      a.data_in = 8'(8'h30 + i); a.write_n = 0;
      cyc();
      chk("thr_geq", a.geq_level, (i == 2));
    end
    a.write_n = 1;
    a.level = 0; #1;
    chk("thr_level0", a.geq_level, 1);
    a.level = 20; #1;
    chk("thr_over", a.geq_level, 0);
    a.level = 3; #1;
    chk("thr_back", a.geq_level, 1);
    for (int i = 3; i < 7; i++) begin
      a.data_in = 8'(8'h30 + i); a.write_n = 0;
      cyc();
    end
    a.write_n = 1;
    chk("pre_flush_count", a.count, 7);
    a.flush = 1; a.read_n = 0; a.write_n = 0;
    cyc();
    a.flush = 0; a.read_n = 1; a.write_n = 1;
    chk("flush_count", a.count, 0);
    chk("flush_empty", a.empty, 1);
    chk("flush_dout", a.data_out, 8'h77);
    chk("flush_dv", a.data_valid, 0);
    chk("flush_ovf", a.overflow, 0);
    chk("flush_unf", a.underflow, 0);
    a.data_in = 8'h99; a.write_n = 0;
    cyc();
    a.write_n = 1; a.read_n = 0;
    chk("post_flush_count", a.count, 1);
    cyc();
    chk("post_flush_dout", a.data_out, 8'h99);
    cyc();
    a.read_n = 1;
    chk("post_flush_unf", a.underflow, ERR);
    reset = 1;
    cyc();
    reset = 0;
    chk("rst2_dout", a.data_out, 0);
    chk("rst2_dv", a.data_valid, 0);
    chk("rst2_unf", a.underflow, 0);
    chk("rst2_count", a.count, 0);
    chk("rst2_empty", a.empty, 1);
    for (int i = 0; i < 5; i++) begin
      b.data_in = 8'(8'hB0 + i); b.write_n = 0;
      cyc();
      chk("b_fill_count", b.count, i + 1);
      chk("b_fill_afull", b.afull, (i >= 3));
      chk("b_fill_full", b.full, (i == 4));
    end
    b.data_in = 8'hFF;
    cyc();
    chk("b_ovf_count", b.count, 5);
    chk("b_ovf_flag", b.overflow, ERR);
    b.write_n = 1; b.read_n = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("b_drain_dout", b.data_out, 8'(8'hB0 + k));
      chk("b_drain_dv", b.data_valid, 1);
    end
    b.read_n = 1;
    chk("b_drain_empty", b.empty, 1);
    for (int i = 0; i < 3; i++) begin
      b.data_in = 8'(8'hA0 + i); b.write_n = 0;
      cyc();
    end
    b.read_n = 0;
    for (int i = 3; i < 12; i++) begin
      b.data_in = 8'(8'hA0 + i);
      cyc();
      chk("b_wrap_dout", b.data_out, 8'(8'hA0 + i - 3));
      chk("b_wrap_dv", b.data_valid, 1);
      chk("b_wrap_count", b.count, 3);
    end
    b.write_n = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("b_tail_dout", b.data_out, 8'(8'hA9 + k));
    end
    b.read_n = 1;
    cyc();
    chk("b_end_dv", b.data_valid, 0);
    chk("b_end_empty", b.empty, 1);
    done = 1'b1;
    if (errors != 0) $error("FAIL %0d of %0d checks failed", errors, checks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_fifo_param.md
Name: uart_fifo_param

Overview:
Parametrised synchronous FIFO for the UART TX/RX data paths. It is the next generation of the fixed 128x8 FIFO controller.
- Generalises width and depth; non-power-of-2 depths are allowed.
- Makes every location usable.
- Adds a runtime threshold flag, an almost-full flag, a flush input and optional overflow/underflow error flags.
- Sits between the UART register interface and the TX/RX shift engines, all on the system clock.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 128, number of storable words (>=2, any integer)
AFULL_MARGIN, 4, afull asserts when count >= DEPTH-AFULL_MARGIN
CNT_BITS, $clog2(DEPTH+1), width of count and level (derived, not overridden)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active high
flush  input  1  synchronous clear of FIFO contents, active high
data_in  input  WIDTH  write data
write_n  input  1  write strobe, active low
read_n  input  1  read strobe, active low
level  input  CNT_BITS  threshold for geq_level
data_out  output  WIDTH  registered read data
data_valid  output  1  one-cycle pulse, data_out updated this cycle
count  output  CNT_BITS  words currently stored
full  output  1  count == DEPTH
empty  output  1  count == 0
afull  output  1  count >= DEPTH-AFULL_MARGIN
geq_level  output  1  count >= level
overflow  output  1  sticky, write attempted while full (feature-dependent)
underflow  output  1  sticky, read attempted while empty (feature-dependent)

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high, reset.
- Reset (reset=1 at rising edge) clears the following:
  - wr/rd pointers = 0, count = 0, data_out = 0, data_valid = 0, overflow = underflow = 0.
  - Resulting flags: empty = 1, full = 0, afull = 0.
  - geq_level follows count combinationally.
  - Memory contents are not cleared.
- Priority at each edge: reset > flush > read/write.
- flush: same clears as reset except data_out, which holds its value. Any read/write strobed in the same cycle is ignored.
- Read accept: rd_acc = ~read_n & ~empty.
- Write accept: wr_acc = ~write_n & (~full | rd_acc).
  - When full, a simultaneous read+write is accepted: count unchanged, both pointers advance.
  - When empty, a simultaneous read+write performs the write only: count +1, data_valid stays 0.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged otherwise. Never exceeds DEPTH and never goes below 0.
- Pointers are 0..DEPTH-1. Each advances on its accept and wraps from DEPTH-1 to 0 (explicit compare, not modulo 2^n).
- Storage: synchronous write at wr_ptr on wr_acc.
- Read latency: data_out loads mem[rd_ptr] on the edge after an rd_acc cycle, and data_valid pulses high for that one cycle. Otherwise data_out holds and data_valid = 0.
  - Back-to-back reads produce back-to-back data_valid pulses.
- A word written in cycle N is readable (empty = 0) from cycle N+1.
- Status flags (full, empty, afull, geq_level) are combinational from count, so they update the cycle after the accepting edge.
  - level = 0 forces geq_level = 1.
  - level > DEPTH forces geq_level = 0.
- Rejected strobes (write when full with no read, read when empty) change no state except the optional error flags.

Optional Feature:
UART_FIFO_ERR_EN
- Defined:
  - overflow sets on ~write_n & full & ~rd_acc.
  - underflow sets on ~read_n & empty.
  - Both are sticky until reset or flush.
- Undefined: overflow and underflow are tied to 0 and their logic is absent. The port list is identical in both builds.

Decomposition:
- Package uart_fifo_pkg holds:
  - the default WIDTH/DEPTH/AFULL_MARGIN constants;
  - a function returning pointer-next-with-wrap for a given depth;
  - a typedef for the status bundle (full, empty, afull, geq_level).
- One sub-module, uart_fifo_mem: simple dual-port array, synchronous write, registered read with enable, no reset. This allows a vendor RAM macro to be substituted later.
- Control, count and flags stay in the top module.

Test Plan:
1. Reset then fill (DEPTH=16, WIDTH=8): 16 writes of 0x00..0x0F -> full=1 after the 16th, count=16, afull=1 from count=12. A 17th write is rejected: count stays 16, overflow=1 (with UART_FIFO_ERR_EN).
2. Drain: 16 reads -> data_out 0x00..0x0F in order, each one cycle after its strobe with a data_valid pulse. empty=1 after the last read. A 17th read gives no data_valid and underflow=1.
3. Simultaneous read+write:
   - When full: count stays 16 and the oldest word is output.
   - When empty: write only, count=1, data_valid=0.
4. Wrap, DEPTH=5 (non-power-of-2): 12 interleaved write/read pairs with data 0xA0+i -> in-order data across pointer wrap, count never exceeds 5.
5. Threshold: level=3, write 3 -> geq_level rises the cycle after the 3rd write. Set level=0 -> geq_level=1 regardless of count.
6. Flush and reset mid-stream with count=7:
   - flush with read_n=0 -> count=0, empty=1, data_out unchanged, no data_valid.
   - reset -> data_out=0, sticky flags cleared.
